bin2bcd_seq: RTL and testbench

Sequential double-dabble converter: takes an unsigned binary value (normally from `SW[7:0]`) and produces packed BCD digits. Each 4-bit digit drives one instance of the seven-segment decoder on `HEX0`–`HEX2`. The block sits directly upstream of the decoders in the `DE1_SoC` top level. It uses a start/busy/done handshake and holds its output between conversions, so the displays never show intermediate shift values.

---
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_bin2bcd_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [W-1:0]        bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [W-1:0]    sr, sr_nx;
    logic [BW-1:0]   acc, acc_nx;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   shifted;
    logic [BW-1:0]   bcd_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            done_nx;

    // Add-3 correction: any digit of 5 or more would overflow past 9 once doubled.
    always_comb begin
        adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    // Corrected accumulator doubled, with the next binary bit entering at the bottom.
    always_comb begin
        shifted = {adj[BW-2:0], sr[W-1]};
    end

    // Next-state and datapath update: load on accept, one iteration per SHIFT cycle.
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        acc_nx   = acc;
        cnt_nx   = cnt;
        bcd_nx   = bcd;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sr_nx    = bin;
                    acc_nx   = '0;
                    cnt_nx   = CW'(W);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                acc_nx = shifted;
                sr_nx  = sr << 1;
                cnt_nx = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    bcd_nx   = shifted;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers; reset wins over any conversion in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            bcd   <= bcd_nx;
            done  <= done_nx;
        end
    end

    // Busy reflects the SHIFT state directly.
    always_comb begin
        busy = (state == SHIFT);
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int n_cmp;
    int n_bad;

    bin2bcd_seq #(.W(8), .DIGITS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept bin=v, then wait for done; returns edges from accept to done.
    task automatic convert(input logic [7:0] v, output int lat);
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    function automatic int ref_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    initial begin
        int lat;
        int cnt_busy;
        int cnt_done;
        int gap;
        logic [11:0] keep;
        bit nib_ok;

        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        bin     = 8'd0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_bcd", bcd, 12'h000);
        reset_n = 1'b1;
        tick();

        // bin=0: busy for 8 cycles, one done pulse right after
        bin = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        cnt_busy = 0; cnt_done = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy) cnt_busy++;
            if (done) begin
                cnt_done++;
                check("zero_done_after_busy", cnt_busy, 8);
                check("zero_bcd", bcd, 12'h000);
            end
            tick();
        end
        check("zero_busy_cycles", cnt_busy, 8);
        check("zero_done_count", cnt_done, 1);

        // Single conversions with latency and pulse width checks
        convert(8'd255, lat);
        check("lat_255", lat, 8);
        check("busy_in_done_cycle", busy, 0);
        check("bcd_255", bcd, 12'h255);
        tick();
        check("done_width_255", done, 0);
        check("bcd_hold_255", bcd, 12'h255);

        convert(8'd99, lat);
        check("bcd_99", bcd, 12'h099);
        tick();
        convert(8'd100, lat);
        check("bcd_100", bcd, 12'h100);
        tick();

        // start during SHIFT is ignored and bin changes do not leak in
        bin = 8'd200; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        bin = 8'd17; start = 1'b1;
        tick();
        start = 1'b0;
        cnt_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                cnt_done++;
                check("bcd_200", bcd, 12'h200);
            end
            tick();
        end
        check("ignore_start_done_count", cnt_done, 1);
        check("ignore_start_idle", busy, 0);
        check("ignore_start_bcd_hold", bcd, 12'h200);

        // Reset mid-conversion at E4
        bin = 8'd123; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_bcd", bcd, 12'h000);
        reset_n = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) cnt_done++;
            if (busy) cnt_done++;
            tick();
        end
        check("midrst_no_activity", cnt_done, 0);

        // Back-to-back: start held through the done cycle
        convert(8'd128, lat);
        bin = 8'd7;
        check("b2b_first_bcd", bcd, 12'h128);
        check("b2b_first_done", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        gap = 1;
        while (!done && gap < 20) begin
            tick();
            gap++;
        end
        check("b2b_gap", gap, 9);
        check("b2b_second_bcd", bcd, 12'h007);
        tick();

        // Exhaustive sweep over all 8-bit inputs
        for (int v = 0; v < 256; v++) begin
            convert(v[7:0], lat);
            check($sformatf("sweep_%0d", v), bcd, ref_bcd(v));
            keep   = bcd;
            nib_ok = (keep[3:0] <= 4'd9) && (keep[7:4] <= 4'd9) && (keep[11:8] <= 4'd9);
            check($sformatf("nibble_%0d", v), nib_ok, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
